// File: rtl/mult_pkg.sv
// Shared types for the 4x4 shift-add multiplier, its result collector and benches.
package mult_pkg;
  localparam int PW    = 8;
  localparam int TW    = 4;
  localparam int ACC_W = 16;

  typedef logic [PW-1:0] product_t;
  typedef logic [TW-1:0] tag_t;

  typedef struct packed {
    tag_t     tag;
    product_t data;
  } entry_t;
endpackage

// File: rtl/mult_result_fifo_sync_fifo.sv
// Generic synchronous FIFO: DEPTH x WIDTH storage, wrapping pointers, occupancy count.
module sync_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO only lands when the head leaves on the same edge.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/mult_result_fifo.sv
// Collects each completed multiplier product once into a tagged FIFO,
// keeping a running sum and a sticky drop flag.
module mult_result_fifo
  import mult_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = mult_pkg::PW,
  parameter int TW    = mult_pkg::TW
) (
  input  logic                   CK,
  input  logic                   RST,
  input  logic                   START,
  input  logic                   READY,
  input  logic [PW-1:0]          P,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic [PW-1:0]          OUT_DATA,
  output logic [TW-1:0]          OUT_TAG,
  output logic [ACC_W-1:0]       ACC,
  input  logic                   ACC_CLR,
  output logic                   OVF,
  output logic [$clog2(DEPTH):0] COUNT
);
  logic          armed;
  logic          ready_q;
  logic [TW-1:0] tag_ctr;
  logic          cap;
  logic          pop;
  logic          push_ok;
  logic          full;
  logic          empty;
  logic [TW+PW-1:0] head;

  // The multiplier is not reset, so READY means nothing until a START has been seen.
  assign cap     = armed & READY & ~ready_q & ~START;
  assign pop     = OUT_VALID & OUT_READY;
  assign push_ok = cap & (~full | pop);

  assign OUT_VALID           = ~empty;
  assign {OUT_TAG, OUT_DATA} = head;

  sync_fifo #(
    .WIDTH (TW+PW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CK),
    .rst   (RST),
    .push  (push_ok),
    .pop   (pop),
    .wdata ({tag_ctr, P}),
    .rdata (head),
    .count (COUNT),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge CK) begin
    if (RST) begin
      armed   <= 1'b0;
      ready_q <= 1'b1;
      tag_ctr <= '0;
      ACC     <= '0;
      OVF     <= 1'b0;
    end else begin
      ready_q <= READY;
      if (START)   armed   <= 1'b1;
      if (push_ok) tag_ctr <= tag_ctr + 1'b1;
      if (ACC_CLR)      ACC <= '0;
      else if (push_ok) ACC <= ACC + ACC_W'(P);
      if (cap && !push_ok) OVF <= 1'b1;
    end
  end
endmodule
